// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package wide_add_sequencer_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word-index width; at least one bit so the index register is never zero-width.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// Purely combinational 16-bit ripple-carry adder used as the shared word slice.
module full_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  // Ripple the carry bit by bit from LSB to MSB.
  always_comb begin
    logic cy;
    s  = '0;
    cy = ci;
    for (int i = 0; i < 16; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract sequencer: feeds one 16-bit word per cycle,
// LSB word first, through a single shared adder and keeps the carry in a
// register between words.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*16-1:0]   A,
  input  logic [WORDS*16-1:0]   B,
  input  logic                  Sub,
  input  logic                  Cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*16-1:0]   Sum,
  output logic                  Cout,
  output logic                  Ovf,
  output logic                  busy
);

  localparam int W  = WORDS * WORD_W;
  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic [IW-1:0]     idx_q;

  logic              in_hs, out_hs, last_word;
  logic [WORD_W-1:0] a_word, b_word, s_word;
  logic              co_word;

  assign in_hs     = (state_q == IDLE) && in_valid;
  assign out_hs    = (state_q == DONE) && out_ready;
  assign last_word = (idx_q == LAST_IDX);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_word) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture; B is stored already inverted for subtraction.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      a_q <= A;
      b_q <= Sub ? ~B : B;
    end
  end

  // Select the current word of each operand for the shared adder.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IW'(w)) begin
        a_word = a_q[w*WORD_W +: WORD_W];
        b_word = b_q[w*WORD_W +: WORD_W];
      end
    end
  end

  full_adder_16bit u_adder (
    .a  (a_word),
    .b  (b_word),
    .ci (carry_q),
    .s  (s_word),
    .co (co_word)
  );

  // Word sequencing: index, carry chain, result words and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (in_hs) begin
      idx_q   <= '0;
      carry_q <= Cin;
    end else if (state_q == RUN) begin
      carry_q <= co_word;
      for (int w = 0; w < WORDS; w++) begin
        if (idx_q == IW'(w)) sum_q[w*WORD_W +: WORD_W] <= s_word;
      end
      if (last_word) begin
        cout_q <= co_word;
        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (s_word[WORD_W-1] != a_q[W-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

  // A pending drain has no effect on data; DONE simply holds its registers.
  logic unused_ok;
  assign unused_ok = out_hs;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed self-checking bench for wide_add_sequencer with WORDS=4.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         Sub, Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout, Ovf, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sub       (Sub),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands and complete the input handshake on the next edge.
  task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
    int g;
    g = 0;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    A = a; B = b; Sub = sub; Cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the handshake edge until out_valid rises (bounded).
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    do begin
      if (lat != 0) begin @(posedge clk); #1; end
      lat++;
    end while (0);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    // Handshake in cycle T -> out_valid from cycle T+5, i.e. 4 edges after the handshake edge.
    chk({tag, "_latency"}, W'(lat), W'(WORDS));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] es,
                              input logic ec, input logic eo);
    chk({tag, "_out_valid"}, W'(out_valid), W'(1));
    chk({tag, "_sum"},  Sum, es);
    chk({tag, "_cout"}, W'(Cout), W'(ec));
    chk({tag, "_ovf"},  W'(Ovf),  W'(eo));
    chk({tag, "_busy"}, W'(busy), W'(1));
    chk({tag, "_in_ready_done"}, W'(in_ready), W'(0));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drained_valid"}, W'(out_valid), W'(0));
    chk({tag, "_drained_busy"},  W'(busy), W'(0));
    chk({tag, "_drained_ready"}, W'(in_ready), W'(1));
  endtask

  task automatic run_case(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    start_op(tag, a, b, sub, cin);
    wait_done(tag);
    check_result(tag, es, ec, eo);
    drain(tag);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Sub = 1'b0; Cin = 1'b0;
    #2;
    chk("rst_sum",       Sum,            '0);
    chk("rst_cout",      W'(Cout),       W'(0));
    chk("rst_ovf",       W'(Ovf),        W'(0));
    chk("rst_out_valid", W'(out_valid),  W'(0));
    chk("rst_busy",      W'(busy),       W'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  W'(in_ready),   W'(1));

    // Carry from word 0 into word 1.
    run_case("c1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
             64'h0000_0000_0001_0000, 1'b0, 1'b0);
    // Carry ripples through every word.
    run_case("c2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
             64'h0, 1'b1, 1'b0);
    // Subtraction with borrow, then without.
    run_case("c3a", 64'h5, 64'h7, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_case("c3b", 64'h7, 64'h5, 1'b1, 1'b1,
             64'h2, 1'b1, 1'b0);
    // Positive signed overflow.
    run_case("c4", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Backpressure: stall in DONE while new operands are offered.
    start_op("c5", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    wait_done("c5");
    check_result("c5", 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
    A = 64'h8000_0000_0000_0000; B = 64'h8000_0000_0000_0000;
    Sub = 1'b0; Cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("c5_stall_valid", W'(out_valid), W'(1));
      chk("c5_stall_sum",   Sum, 64'h2345_6789_ABCD_F001);
      chk("c5_stall_cout",  W'(Cout), W'(0));
      chk("c5_stall_ovf",   W'(Ovf),  W'(0));
      chk("c5_stall_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    drain("c5");
    run_case("c5n", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
             64'h0, 1'b1, 1'b1);

    // Reset two cycles into RUN aborts the operation.
    start_op("c6", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("c6_pre_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    chk("c6_rst_sum",   Sum, '0);
    chk("c6_rst_valid", W'(out_valid), W'(0));
    chk("c6_rst_busy",  W'(busy), W'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("c6_rel_ready", W'(in_ready), W'(1));
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("c6_no_spurious_valid", W'(seen), W'(0));
    run_case("c6r", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
             64'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-precision add/subtract sequencer built around one shared 16-bit ripple adder word slice.
- Accepts two WORDS×16-bit operands over a valid/ready handshake.
- Sends one 16-bit word per cycle through the adder, least-significant word first, and holds the carry in a register between words.
- Returns the full-width result, carry-out and signed-overflow flag on a second valid/ready handshake.
- Sits between the 16-bit adder datapath and any requester that needs wider arithmetic without replicating adders.

Parameters:
WORDS, 4, number of 16-bit words per operand (legal range 2..16); operand width is WORDS*16.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  sequencer can accept a request (high only in IDLE).
A  input  WORDS*16  operand A, sampled on the input handshake.
B  input  WORDS*16  operand B, sampled on the input handshake.
Sub  input  1  0: Sum=A+B+Cin; 1: Sum=A+~B+Cin (A−B requires Cin=1); sampled on the input handshake.
Cin  input  1  initial carry into word 0; sampled on the input handshake.
out_valid  output  1  result valid (high only in DONE).
out_ready  input  1  consumer accepts the result.
Sum  output  WORDS*16  registered result.
Cout  output  1  carry out of the top word (raw carry; for Sub=1, 0 means borrow).
Ovf  output  1  signed two's-complement overflow of the full-width operation.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; word index=0; carry register=0.
  - Sum=0, Cout=0, Ovf=0, out_valid=0, in_ready=1 (once rst_n=1), busy=0.
- States: IDLE, RUN, DONE (3-state FSM).
- IDLE:
  - in_ready=1.
  - Input handshake is in_valid & in_ready at cycle T.
  - On handshake: latch A, Sub, Cin, and B_eff = Sub ? ~B : B into operand registers; carry register = Cin; index = 0; go to RUN.
  - in_valid is ignored in every other state.
- RUN:
  - Each cycle, word index i feeds A[i*16+:16], B_eff[i*16+:16] and the carry register to the adder.
  - Sum word i and the carry register are written from the adder outputs.
  - index increments by 1.
  - When i = WORDS−1:
    - Cout = adder carry out.
    - Ovf = (A_msb == B_eff_msb) & (Sum_msb != A_msb), using bit WORDS*16−1.
    - Go to DONE.
  - Index never wraps past WORDS−1.
- Latency: the input handshake at cycle T gives out_valid=1 from cycle T+WORDS+1. Throughput is one operation per WORDS+2 cycles minimum.
- DONE:
  - out_valid=1.
  - Sum, Cout and Ovf stay stable while out_ready=0; stalling may last any number of cycles.
  - On out_valid & out_ready: go to IDLE and drop out_valid the next cycle.
  - in_ready stays 0 in DONE; no same-cycle result-drain-and-accept.
- Sum contents during RUN are partial and undefined for checking. Only values present while out_valid=1 are architecturally meaningful.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. The result is discarded and no out_valid pulse occurs.
- The carry register is the only inter-word state; the adder itself is purely combinational.

Decomposition:
- Shared package holds:
  - WORD_W = 16 constant.
  - State enum {IDLE, RUN, DONE}.
  - Index width function clog2(WORDS).
- One sub-module: a single instance of the existing full_adder_16bit as the word datapath. The sequencer holds only registers, the FSM and word muxing.

Test Plan (WORDS=4):
1. A=0x0000_0000_0000_FFFF, B=0x1, Sub=0, Cin=0 → Sum=0x0000_0000_0001_0000, Cout=0, Ovf=0; out_valid first high exactly 5 cycles after the handshake.
2. A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, Sub=0, Cin=0 → Sum=0x0, Cout=1, Ovf=0 (carry ripples through all 4 words).
3. A=0x5, B=0x7, Sub=1, Cin=1 → Sum=0xFFFF_FFFF_FFFF_FFFE, Cout=0 (borrow), Ovf=0; repeat with A=0x7, B=0x5 → Sum=0x2, Cout=1.
4. A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, Sub=0, Cin=0 → Sum=0x8000_0000_0000_0000, Ovf=1, Cout=0.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands → out_valid, Sum, Cout and Ovf are unchanged each cycle, in_ready=0 and the new operands are not taken. After out_ready=1, the next handshake accepts the new operands and produces the correct result.
6. Assert rst_n=0 two cycles into RUN → Sum=0, out_valid=0 and busy=0 asynchronously; after release in_ready=1, no spurious out_valid, and the following operation (case 2) completes correctly.
